// File: rtl/uart_prog_ctrl.sv
// UART program-load controller: assembles big-endian bytes into 32-bit words,
// writes them to the instruction ROM while the core is held, then releases it.
module uart_prog_ctrl #(
  parameter int ADDR_W     = 14,
  parameter int MAX_WORDS  = 16384,
  parameter int TIMEOUT    = 1000000,
  parameter int RST_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_pg,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_hold,
  output logic              cpu_rst,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int RC_W   = $clog2(RST_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);
  localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {RUN, HDR_HI, HDR_LO, DATA, RELEASE, ERROR} state_e;

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         asm_q, asm_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [RC_W-1:0]     rc_q, rc_d;
  logic                rom_we_q, rom_we_d;
  logic [31:0]         rom_wdata_q, rom_wdata_d;
  logic                hold_q, hold_d;
  logic                err_q, err_d;

  logic [15:0]         hdr_len;
  logic [16:0]         cnt_next;
  logic                timeout;

  assign hdr_len  = {len_q[15:8], rx_data};
  assign cnt_next = 17'(word_cnt_q) + 17'd1;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    word_idx_d  = word_idx_q;
    word_cnt_d  = word_cnt_q;
    idle_d      = idle_q;
    rc_d        = rc_q;
    rom_we_d    = 1'b0;
    rom_wdata_d = rom_wdata_q;
    err_d       = err_q;
    timeout     = 1'b0;

    if (state_q == HDR_HI || state_q == HDR_LO || state_q == DATA) begin
      if (rx_valid)              idle_d  = '0;
      else if (idle_q == IDLE_MAX) timeout = 1'b1;
      else                       idle_d  = idle_q + 1'b1;
    end

    // The write issued last cycle retires now, advancing the address.
    if (rom_we_q) begin
      word_idx_d = word_idx_q + 1'b1;
      word_cnt_d = word_cnt_q + 1'b1;
    end

    case (state_q)
      RUN, ERROR: begin
        if (start_pg) begin
          state_d    = HDR_HI;
          err_d      = 1'b0;
          word_cnt_d = '0;
          word_idx_d = '0;
          byte_idx_d = '0;
          idle_d     = '0;
        end
      end
      HDR_HI: begin
        if (timeout) state_d = ERROR;
        else if (rx_valid) begin
          len_d[15:8] = rx_data;
          state_d     = HDR_LO;
        end
      end
      HDR_LO: begin
        if (timeout) state_d = ERROR;
        else if (rx_valid) begin
          len_d = hdr_len;
          if (hdr_len == 16'd0) begin
            state_d = RELEASE;
            rc_d    = '0;
          end else if (32'(hdr_len) > MAX_WORDS) begin
            state_d = ERROR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (rom_we_q && cnt_next == {1'b0, len_q}) begin
          state_d = RELEASE;
          rc_d    = '0;
        end else if (timeout) begin
          state_d = ERROR;
        end else if (rx_valid) begin
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == 2'd3) begin
            rom_wdata_d = {asm_q, rx_data};
            rom_we_d    = 1'b1;
          end else begin
            asm_d = {asm_q[15:0], rx_data};
          end
        end
      end
      RELEASE: begin
        if (rc_q == RC_LAST) state_d = RUN;
        else                 rc_d    = rc_q + 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (state_d == ERROR) err_d = 1'b1;
    hold_d = (state_d != RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      len_q       <= '0;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      word_idx_q  <= '0;
      word_cnt_q  <= '0;
      idle_q      <= '0;
      rc_q        <= '0;
      rom_we_q    <= 1'b0;
      rom_wdata_q <= '0;
      hold_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      word_idx_q  <= word_idx_d;
      word_cnt_q  <= word_cnt_d;
      idle_q      <= idle_d;
      rc_q        <= rc_d;
      rom_we_q    <= rom_we_d;
      rom_wdata_q <= rom_wdata_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
    end
  end

  // Hold, core reset and busy are all "not in RUN", so they share one flop.
  assign cpu_hold  = hold_q;
  assign cpu_rst   = hold_q;
  assign busy      = hold_q;
  assign err       = err_q;
  assign rom_we    = rom_we_q;
  assign rom_wdata = rom_wdata_q;
  assign word_cnt  = word_cnt_q;
  assign rom_addr  = hold_q ? word_idx_q : fetch_addr;

endmodule

// File: tb/tb_uart_prog_ctrl.sv
// Directed testbench for uart_prog_ctrl: loads, zero length, oversize header,
// inter-byte timeout and asynchronous reset in the middle of a load.
module tb_uart_prog_ctrl;

  localparam int ADDR_W     = 14;
  localparam int MAX_WORDS  = 16;
  localparam int TIMEOUT    = 20;
  localparam int RST_CYCLES = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              start_pg;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] fetch_addr;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_wdata;
  logic              cpu_hold;
  logic              cpu_rst;
  logic              busy;
  logic              err;
  logic [ADDR_W:0]   word_cnt;

  int tests = 0;
  int fails = 0;
  int we_seen = 0;
  int we_base;
  logic [31:0] rom_model [0:15];

  uart_prog_ctrl #(
    .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .start_pg(start_pg), .rx_valid(rx_valid),
    .rx_data(rx_data), .fetch_addr(fetch_addr), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_wdata(rom_wdata), .cpu_hold(cpu_hold), .cpu_rst(cpu_rst), .busy(busy),
    .err(err), .word_cnt(word_cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rom_we === 1'b1) begin
      we_seen++;
      rom_model[rom_addr[3:0]] = rom_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic start_load();
    start_pg = 1'b1;
    tick();
    start_pg = 1'b0;
  endtask

  task automatic load_two();
    send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    chk("w0_we", rom_we, 1);
    chk("w0_addr", rom_addr, 0);
    chk("w0_data", rom_wdata, 32'h12345678);
    chk("w0_cnt_pending", word_cnt, 0);
    send(8'h9A);
    chk("w0_we_drop", rom_we, 0);
    chk("w0_cnt", word_cnt, 1);
    chk("w1_idx", rom_addr, 1);
    send(8'hBC); send(8'hDE); send(8'hF0);
    chk("w1_we", rom_we, 1);
    chk("w1_addr", rom_addr, 1);
    chk("w1_data", rom_wdata, 32'h9ABCDEF0);
    tick();
    chk("w1_we_drop", rom_we, 0);
    chk("load_cnt", word_cnt, 2);
    chk("rel_hold", cpu_hold, 1);
    repeat (RST_CYCLES - 1) tick();
    chk("rel_hold_last", cpu_hold, 1);
    chk("rel_rst_last", cpu_rst, 1);
    tick();
    chk("run_hold", cpu_hold, 0);
    chk("run_rst", cpu_rst, 0);
    chk("run_busy", busy, 0);
    chk("run_err", err, 0);
    chk("model_w0", rom_model[0], 32'h12345678);
    chk("model_w1", rom_model[1], 32'h9ABCDEF0);
    fetch_addr = 14'h2ABC;
    #1;
    chk("run_addr_mux", rom_addr, 14'h2ABC);
    fetch_addr = 14'h0005;
    #1;
    chk("run_addr_mux2", rom_addr, 14'h0005);
  endtask

  initial begin
    reset = 1'b1; start_pg = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    fetch_addr = 14'h0005;
    repeat (3) tick();
    chk("rst_we", rom_we, 0);
    chk("rst_wdata", rom_wdata, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_cpurst", cpu_rst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_addr", rom_addr, 14'h0005);
    reset = 1'b0;
    tick();
    rx_valid = 1'b1; rx_data = 8'h55;
    tick();
    rx_valid = 1'b0;
    chk("run_ignore_rx", busy, 0);

    // Two-word load
    start_load();
    chk("start_hold", cpu_hold, 1);
    chk("start_rst", cpu_rst, 1);
    chk("start_busy", busy, 1);
    chk("start_addr", rom_addr, 0);
    load_two();

    // Zero length
    we_base = we_seen;
    start_load();
    send(8'h00); send(8'h00);
    chk("zl_hold", cpu_hold, 1);
    repeat (RST_CYCLES - 1) tick();
    chk("zl_hold_last", cpu_hold, 1);
    tick();
    chk("zl_run", busy, 0);
    chk("zl_cnt", word_cnt, 0);
    chk("zl_err", err, 0);
    chk("zl_no_we", we_seen - we_base, 0);

    // Oversize header
    start_load();
    send(8'h00); send(8'h11);
    chk("ov_err", err, 1);
    chk("ov_rst", cpu_rst, 1);
    repeat (5) tick();
    chk("ov_err_sticky", err, 1);
    chk("ov_hold", cpu_hold, 1);
    chk("ov_no_we", we_seen - we_base, 0);
    start_load();
    chk("ov_clear", err, 0);
    chk("ov_restart_busy", busy, 1);
    load_two();

    // Timeout
    we_base = we_seen;
    start_load();
    send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
    repeat (TIMEOUT - 1) tick();
    chk("to_not_yet", err, 0);
    tick();
    chk("to_err", err, 1);
    chk("to_hold", cpu_hold, 1);
    chk("to_no_we", we_seen - we_base, 0);
    chk("to_cnt", word_cnt, 0);

    // Asynchronous reset in the middle of word 1
    start_load();
    chk("ar_clear", err, 0);
    send(8'h00); send(8'h02); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55);
    chk("ar_cnt1", word_cnt, 1);
    send(8'h66);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_hold", cpu_hold, 0);
    chk("ar_rst", cpu_rst, 0);
    chk("ar_busy", busy, 0);
    chk("ar_cnt", word_cnt, 0);
    chk("ar_wdata", rom_wdata, 0);
    chk("ar_addr", rom_addr, 14'h0005);
    chk("ar_word0", rom_model[0], 32'h11223344);
    tick();
    reset = 1'b0;
    start_load();
    chk("ar_fresh_addr", rom_addr, 0);
    send(8'h00); send(8'h01); send(8'hCA); send(8'hFE); send(8'hBA); send(8'hBE);
    chk("ar_fresh_we", rom_we, 1);
    chk("ar_fresh_addr0", rom_addr, 0);
    chk("ar_fresh_data", rom_wdata, 32'hCAFEBABE);
    tick();
    chk("ar_fresh_cnt", word_cnt, 1);
    repeat (RST_CYCLES) tick();
    chk("ar_fresh_run", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_prog_ctrl.md
# uart_prog_ctrl

UART program-load controller for the instruction side of the single-cycle CPU. It takes bytes from the UART receiver and assembles them into 32-bit instruction words. It writes those words into the instruction ROM (prgrom), holding the fetch unit (PC/Ifetc32) stalled and in reset while it does so. Once loading ends, it releases the core to fetch from address 0. In run mode it passes the fetch unit's word address straight through to the ROM port.

## Interface
Parameters:
- ADDR_W, 14, ROM word-address width (16384 words × 32 bit)
- MAX_WORDS, 16384, largest accepted image length in words
- TIMEOUT, 1000000, idle clock cycles allowed between bytes before an abort
- RST_CYCLES, 4, cycles cpu_rst stays high after the last write

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start_pg  in  1  one-cycle pulse that requests program mode
- rx_valid  in  1  one-cycle strobe: rx_data holds a valid byte
- rx_data  in  8  received byte
- fetch_addr  in  ADDR_W  fetch unit word address (PC[ADDR_W+1:2])
- rom_we  out  1  ROM write enable, one-cycle pulse per word
- rom_addr  out  ADDR_W  ROM address (muxed)
- rom_wdata  out  32  assembled word
- cpu_hold  out  1  stalls PC update in the fetch unit
- cpu_rst  out  1  holds the core in reset
- busy  out  1  high in any state other than RUN
- err  out  1  sticky: last load was aborted
- word_cnt  out  ADDR_W+1  number of words written by the last load

## Operation
- States: RUN, HDR_HI, HDR_LO, DATA, RELEASE, ERROR.
- **RUN**
  - cpu_hold=0, cpu_rst=0.
  - rx_valid is ignored.
  - start_pg moves to HDR_HI and clears err, word_cnt, the byte index and the word index. cpu_hold and cpu_rst go to 1 on the same edge.
- **Header**
  - HDR_HI: the first byte is len[15:8].
  - HDR_LO: the second byte is len[7:0].
  - The length is big-endian, in words.
  - On the HDR_LO byte:
    - len==0 → RELEASE.
    - len>MAX_WORDS → ERROR.
    - Otherwise → DATA.
- **DATA**
  - Bytes arrive big-endian, first byte = word[31:24].
  - On the 4th byte of a word: register rom_wdata, pulse rom_we for the next cycle with rom_addr = word index, then increment the word index and word_cnt.
  - A byte may arrive on every cycle, including the rom_we cycle. Byte assembly never stalls.
  - After the write pulse for word len-1 → RELEASE.
- **RELEASE**
  - cpu_hold=1, cpu_rst=1 for RST_CYCLES cycles.
  - Then cpu_hold and cpu_rst drop together and the state returns to RUN.
- **ERROR**
  - err=1, cpu_hold=1, cpu_rst=1, no ROM writes.
  - Exits only on start_pg, which enters HDR_HI and clears err.
- **Timeout**
  - In HDR_HI, HDR_LO and DATA, an idle counter counts cycles without rx_valid and resets on each byte.
  - When it reaches TIMEOUT → ERROR.
  - A partial word is discarded; words already written stay in the ROM.
- start_pg is ignored in HDR_HI, HDR_LO, DATA and RELEASE.
- rom_addr mux:
  - When cpu_hold=1, rom_addr = registered word index.
  - Otherwise rom_addr = fetch_addr, combinationally, with zero added latency.

## Timing
- Reset values:
  - state RUN
  - rom_we 0
  - rom_wdata 0
  - cpu_hold 0
  - cpu_rst 0
  - busy 0
  - err 0
  - word_cnt 0
  - internal indices and counters 0
- start_pg sampled at edge N: cpu_hold=cpu_rst=busy=1 from edge N.
- 4th byte of word k sampled at edge M: rom_we=1 and rom_addr=k in cycle M..M+1; rom_we=0 from edge M+1; word_cnt=k+1 from edge M+1.
- Last write pulse ends at edge M+1: cpu_rst and cpu_hold fall at edge M+1+RST_CYCLES.
- err is set on the edge that enters ERROR.
- All outputs except rom_addr in run mode are registered.
- Asynchronous reset mid-load returns to RUN immediately. The partial image stays in the ROM, and the core runs whatever the ROM holds.

## Test plan
- Reset check: assert reset, then drive fetch_addr=0x0005. Required: every output at its reset value, rom_addr=0x0005, busy=0.
- Two-word load: start_pg, then bytes 00 02 12 34 56 78 9A BC DE F0 on consecutive cycles. Required:
  - rom_we pulse at addr 0 with data 0x12345678.
  - rom_we pulse at addr 1 with data 0x9ABCDEF0.
  - word_cnt=2.
  - cpu_rst and cpu_hold fall exactly RST_CYCLES cycles after the second pulse; rom_addr then tracks fetch_addr.
- Zero length: start_pg, bytes 00 00. Required: no rom_we, RELEASE for RST_CYCLES, then RUN with word_cnt=0 and err=0.
- Oversize header: with MAX_WORDS=16, send 00 11. Required: ERROR, err=1, cpu_rst=1, no writes. A later start_pg clears err and the two-word load then succeeds.
- Timeout: with TIMEOUT=20, send 00 01 AA BB, then stall. Required: ERROR 20 cycles after the BB byte, no rom_we, cpu_hold stays 1.
- Async reset mid-DATA: assert reset between bytes of word 1. Required: all outputs reset immediately, without a clock edge; word 0 remains written; start_pg afterwards begins a fresh load at addr 0.
